// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the program-counter stage.
//   - pc_state_e       : PC stage run state (RUN / HALTED)
//   - PC_INCR          : sequential fetch increment (one 32-bit word)
//   - DEFAULT_RESET_PC : PC value loaded on reset unless overridden
//   - word_align()     : clears the byte-offset bits of an address/offset
//   - jump_target()    : builds the j-type target from PC+4 and instr[25:0]
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned, so bits [1:0] never carry
    // information; forcing them to zero keeps every PC source aligned.
    function automatic logic [31:0] word_align(input logic [31:0] value);
        return value & ~32'd3;
    endfunction

    // j-type target: top nibble of the incremented PC, 26-bit word index,
    // then the implicit 2'b00 byte offset.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] instr_index);
        return {pc_plus4[31:28], instr_index, 2'b00};
    endfunction

endpackage : mips_pkg

// File: rtl/pc_somador.sv
// -----------------------------------------------------------------------------
// pc_somador
//   Plain W-bit unsigned adder, result modulo 2^W (carry-out discarded).
//   Used twice by pc_proximo: PC + 4 and PC + 4 + branch offset.
// Ports
//   a_i    in  W  first operand
//   b_i    in  W  second operand
//   soma_o out W  (a_i + b_i) mod 2^W
// -----------------------------------------------------------------------------
module pc_somador #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] soma_o
);

    // Wraparound is intentional: negative branch offsets arrive in two's
    // complement and rely on the dropped carry.
    assign soma_o = a_i + b_i;

endmodule : pc_somador

// File: rtl/pc_proximo.sv
// -----------------------------------------------------------------------------
// pc_proximo
//   Program-counter stage. Holds the architectural PC, computes PC+4, the
//   branch target (PC+4 + pre-shifted offset) and the jump target, and
//   registers the selected next PC once per clock. Supports stall and halt.
//
// Parameters
//   RESET_PC  PC loaded on reset (bits [1:0] are forced to 0)
//   COUNT_W   width of the taken-branch counter (stats build only)
//
// Build option
//   PC_BRANCH_STATS_EN  when defined, adds the BranchCount output and a
//                       wrapping counter of taken branches that actually
//                       redirected the PC.
//
// Ports
//   clk          in   1   clock, all state on the rising edge
//   reset        in   1   synchronous, active-high, highest priority
//   desloca      in   32  branch offset, already <<2 (bits [1:0] ignored)
//   Branch       in   1   current instruction is beq
//   Zero         in   1   ALU zero flag
//   Jump         in   1   current instruction is j
//   JumpAddr     in   26  instruction bits [25:0]
//   Stall        in   1   hold PC this cycle
//   Halt         in   1   enter HALTED at this edge
//   PC           out  32  registered current PC
//   PCPlus4      out  32  combinational PC + 4
//   BranchTaken  out  1   combinational Branch & Zero & ~Jump while RUN
//   Halted       out  1   registered, high while HALTED
//   BranchCount  out  COUNT_W  taken-branch count (stats build only)
// -----------------------------------------------------------------------------
module pc_proximo
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        desloca,
    input  logic               Branch,
    input  logic               Zero,
    input  logic               Jump,
    input  logic [25:0]        JumpAddr,
    input  logic               Stall,
    input  logic               Halt,
    output logic [31:0]        PC,
    output logic [31:0]        PCPlus4,
    output logic               BranchTaken,
    output logic               Halted
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [COUNT_W-1:0] BranchCount
`endif
);

    localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    pc_state_e   state_q;
    logic        halted_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // -------------------------------------------------------------------------
    // Datapath: two adders and the jump concatenation
    // -------------------------------------------------------------------------
    logic [31:0] pc_plus4;
    logic [31:0] desloca_aligned;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;

    assign desloca_aligned = word_align(desloca);

    pc_somador #(.W(32)) u_pc_incr (
        .a_i    (pc_q),
        .b_i    (PC_INCR),
        .soma_o (pc_plus4)
    );

    pc_somador #(.W(32)) u_branch_add (
        .a_i    (pc_plus4),
        .b_i    (desloca_aligned),
        .soma_o (branch_target)
    );

    assign jump_addr = jump_target(pc_plus4, JumpAddr);

    // -------------------------------------------------------------------------
    // Control
    // -------------------------------------------------------------------------
    logic in_run;
    logic branch_taken;
    logic advance;

    assign in_run       = (state_q == RUN);
    // Jump outranks the branch, so a simultaneous beq is not "taken".
    assign branch_taken = in_run & Branch & Zero & ~Jump;
    // The PC only moves on an edge where we are running and neither halt
    // nor stall holds it. Halt is checked here as well so a halt that
    // arrives together with a jump/branch suppresses the redirect.
    assign advance      = in_run & ~Halt & ~Stall;

    // Next-PC select: Halt/Stall hold > Jump > taken branch > PC+4.
    // A stalled jump is dropped; the control path must re-present it.
    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            if (Jump) begin
                pc_d = jump_addr;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM + PC register. HALTED is only left through reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC_ALIGNED;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                RUN: begin
                    if (Halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Optional taken-branch statistics
    // -------------------------------------------------------------------------
`ifdef PC_BRANCH_STATS_EN
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // Only branches that actually redirected the PC are counted; counter
    // wraps naturally at 2^COUNT_W.
    always_comb begin
        count_d = count_q;
        if (advance && branch_taken) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign BranchCount = count_q;
`else
    // COUNT_W only sizes the statistics counter, which is absent here.
    if (COUNT_W > 0) begin : g_stats_disabled
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign BranchTaken = branch_taken;
    assign Halted      = halted_q;

endmodule : pc_proximo

// File: tb/tb_pc_proximo.sv
// -----------------------------------------------------------------------------
// tb_pc_proximo
//   Self-checking bench for pc_proximo: a directed vector table, hand-written
//   halt/stall/reset sequences and randomized cycles, all compared against a
//   behavioural model. A second instance with RESET_PC = 32'hFFFF_FFFC
//   covers the PC+4 wraparound. Build with +define+PC_BRANCH_STATS_EN to
//   also check BranchCount.
// -----------------------------------------------------------------------------
module tb_pc_proximo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, Branch, Zero, Jump, Stall, Halt;
    logic [25:0] JumpAddr;
    logic [31:0] desloca;
    logic [31:0] PC, PCPlus4, PC2, PCPlus4_2;
    logic        BranchTaken, Halted, BranchTaken2, Halted2;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0] BranchCount, BranchCount2;
`endif

    pc_proximo #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .desloca(desloca), .Branch(Branch),
        .Zero(Zero), .Jump(Jump), .JumpAddr(JumpAddr), .Stall(Stall),
        .Halt(Halt), .PC(PC), .PCPlus4(PCPlus4), .BranchTaken(BranchTaken),
        .Halted(Halted)
`ifdef PC_BRANCH_STATS_EN
        , .BranchCount(BranchCount)
`endif
    );

    pc_proximo #(.RESET_PC(32'hFFFF_FFFC), .COUNT_W(32)) dut_wrap (
        .clk(clk), .reset(reset), .desloca(desloca), .Branch(Branch),
        .Zero(Zero), .Jump(Jump), .JumpAddr(JumpAddr), .Stall(Stall),
        .Halt(Halt), .PC(PC2), .PCPlus4(PCPlus4_2), .BranchTaken(BranchTaken2),
        .Halted(Halted2)
`ifdef PC_BRANCH_STATS_EN
        , .BranchCount(BranchCount2)
`endif
    );

    typedef struct {
        logic        rst, br, zr, jp;
        logic [25:0] ja;
        logic [31:0] ds;
        logic        st, ht;
        logic [31:0] exp_pc;
        logic        chk;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Behavioural reference state
    logic [31:0] m_pc, m_pc2, m_cnt;
    logic        m_halted;
    bit          m_valid = 1'b0;

    function automatic vec_t mk(logic rst, logic br, logic zr, logic jp,
                                logic [25:0] ja, logic [31:0] ds, logic st,
                                logic ht, logic [31:0] exp_pc);
        vec_t v;
        v.rst = rst; v.br = br; v.zr = zr; v.jp = jp; v.ja = ja; v.ds = ds;
        v.st = st; v.ht = ht; v.exp_pc = exp_pc; v.chk = 1'b1;
        return v;
    endfunction

    function automatic vec_t rnd_vec(int p_rst, int p_halt);
        vec_t v;
        v.rst = ($urandom_range(99) < p_rst);
        v.ht  = ($urandom_range(99) < p_halt);
        v.st  = ($urandom_range(99) < 20);
        v.jp  = ($urandom_range(99) < 15);
        v.br  = ($urandom_range(99) < 40);
        v.zr  = ($urandom_range(99) < 50);
        v.ja  = 26'($urandom);
        v.ds  = $urandom;
        v.exp_pc = 32'h0;
        v.chk = 1'b0;
        return v;
    endfunction

    // Next PC in RUN when the PC advances, from the stated rules.
    function automatic logic [31:0] ref_next(logic [31:0] pc, vec_t v);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (v.jp)             return {p4[31:28], v.ja, 2'b00};
        if (v.br && v.zr)     return p4 + (v.ds & 32'hFFFF_FFFC);
        return p4;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive, check combinational outputs, clock, update model,
    // check registered outputs. Entered and left at posedge + 1.
    task automatic step(vec_t v, string tag);
        reset = v.rst; Branch = v.br; Zero = v.zr; Jump = v.jp;
        JumpAddr = v.ja; desloca = v.ds; Stall = v.st; Halt = v.ht;
        #1;
        if (m_valid) begin
            check32({tag, " PCPlus4"}, PCPlus4, m_pc + 32'd4);
            check32({tag, " PCPlus4_wrap"}, PCPlus4_2, m_pc2 + 32'd4);
            check32({tag, " BranchTaken"}, {31'd0, BranchTaken},
                    {31'd0, (!m_halted && v.br && v.zr && !v.jp)});
        end
        @(posedge clk);
        if (v.rst) begin
            m_pc = 32'h0; m_pc2 = 32'hFFFF_FFFC; m_halted = 1'b0;
            m_cnt = 32'h0; m_valid = 1'b1;
        end else if (m_valid && !m_halted) begin
            if (v.ht) begin
                m_halted = 1'b1;
            end else if (!v.st) begin
                if (v.br && v.zr && !v.jp) m_cnt = m_cnt + 32'd1;
                m_pc  = ref_next(m_pc, v);
                m_pc2 = ref_next(m_pc2, v);
            end
        end
        #1;
        if (m_valid) begin
            check32({tag, " PC"}, PC, m_pc);
            check32({tag, " PC_wrap"}, PC2, m_pc2);
            check32({tag, " Halted"}, {31'd0, Halted}, {31'd0, m_halted});
`ifdef PC_BRANCH_STATS_EN
            check32({tag, " BranchCount"}, BranchCount, m_cnt);
`endif
        end
        if (v.chk) check32({tag, " PC_table"}, PC, v.exp_pc);
        $display("%s: rst=%b br=%b zr=%b jp=%b st=%b ht=%b -> PC=%h Halted=%b",
                 tag, v.rst, v.br, v.zr, v.jp, v.st, v.ht, PC, Halted);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        reset = 1'b1; Branch = 0; Zero = 0; Jump = 0; Stall = 0; Halt = 0;
        JumpAddr = '0; desloca = '0;

        //            rst br zr jp ja        ds             st ht exp_pc
        tbl.push_back(mk(1, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0000));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0004));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0008));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_000C));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0010));
        tbl.push_back(mk(0, 1, 1, 0, 26'h0,   32'h0000_0020, 0, 0, 32'h0000_0034));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0038));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_003C));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         0, 0, 32'h0000_0040));
        tbl.push_back(mk(0, 1, 1, 0, 26'h0,   32'hFFFF_FFF0, 0, 0, 32'h0000_0034));
        tbl.push_back(mk(0, 1, 1, 0, 26'h0,   32'h0FFF_FFC8, 0, 0, 32'h1000_0000));
        tbl.push_back(mk(0, 0, 0, 1, 26'h40,  32'h0,         0, 0, 32'h1000_0100));
        tbl.push_back(mk(0, 1, 1, 1, 26'h80,  32'h0000_0100, 0, 0, 32'h1000_0200));
        tbl.push_back(mk(0, 1, 1, 0, 26'h0,   32'hEFFF_FE1C, 0, 0, 32'h0000_0020));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         1, 0, 32'h0000_0020));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         1, 0, 32'h0000_0020));
        tbl.push_back(mk(0, 0, 0, 0, 26'h0,   32'h0,         1, 0, 32'h0000_0020));
        tbl.push_back(mk(0, 1, 1, 1, 26'h3FF, 32'h40,        1, 0, 32'h0000_0020));

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
            if (i == 0) check32("wrap reset PC", PC2, 32'hFFFF_FFFC);
            if (i == 2) check32("wrap PC+4 to zero", PC2, 32'h0000_0000);
        end

        // Halt together with a taken branch: halt wins, PC frozen at 0x20.
        step(mk(0, 1, 1, 0, 26'h0, 32'h100, 0, 1, 32'h0000_0020), "halt");
        check32("halt Halted", {31'd0, Halted}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            v = rnd_vec(0, 50);
            step(v, $sformatf("halted%0d", k));
            check32("halted PC frozen", PC, 32'h0000_0020);
        end
        // Reset out of HALTED, with Halt still asserted.
        step(mk(1, 0, 0, 1, 26'h55, 32'h0, 1, 1, 32'h0000_0000), "halt_reset");
        check32("halt_reset Halted", {31'd0, Halted}, 32'd0);

        // Offset low bits ignored; branch without Zero falls through.
        step(mk(0, 0, 0, 0, 26'h0, 32'h0,         0, 0, 32'h0000_0004), "seq_a");
        step(mk(0, 1, 1, 0, 26'h0, 32'h0000_0013, 0, 0, 32'h0000_0018), "lowbits");
        step(mk(0, 1, 0, 0, 26'h0, 32'h0000_0100, 0, 0, 32'h0000_001C), "br_nz");
        // Reset during stall.
        step(mk(1, 0, 0, 0, 26'h0, 32'h0,         1, 0, 32'h0000_0000), "stall_rst");

        for (int k = 0; k < 400; k++) begin
            v = rnd_vec(2, 3);
            step(v, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_proximo
